// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pattern_tester
// Brief    : Writes a deterministic pattern over an SDRAM window, reads it back
//            and reports pass/fail, error count and first failing word.
//            Optional macro PATTERN_LFSR_EN selects a 16-bit Galois LFSR pattern.
// Revision : 1.0
// ============================================================================
module sdram_pattern_tester #(
    parameter int          ADDR_WIDTH = 23,
    parameter int          DATA_WIDTH = 16,
    parameter int          BASE_ADDR  = 0,
    parameter int          NUM_WORDS  = 1024,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          ERR_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_bi,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_WIDTH-1:0]  errCnt_o,
    output logic [ADDR_WIDTH-1:0] failAddr_o,
    output logic [DATA_WIDTH-1:0] failData_o,
    output logic                  rd_o,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  opBegun_i,
    input  logic                  done_i,
    input  logic                  rdDone_i,
    input  logic [DATA_WIDTH-1:0] data_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WGAP   = 3'd2,
        S_READ   = 3'd3,
        S_RGAP   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_base = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_last =
        ADDR_WIDTH'(longint'(BASE_ADDR) + longint'(NUM_WORDS) - 64'sd1);
    localparam logic [DATA_WIDTH-1:0] c_seed = DATA_WIDTH'(SEED);
    localparam logic [ERR_WIDTH-1:0]  c_err_max = {ERR_WIDTH{1'b1}};

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ERR_WIDTH-1:0]  r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;
    logic                  r_rd;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_pat;
    logic [DATA_WIDTH-1:0] w_pat_next;
    logic                  w_last;
    logic                  w_unused;

    // opBegun_i carries no information this initiator needs.
    assign w_unused = opBegun_i;
    assign w_last   = (r_addr == c_last);

`ifdef PATTERN_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] c_taps = DATA_WIDTH'(16'hB400);
    always_comb begin
        w_pat_next = r_pat >> 1;
        if (r_pat[0]) begin
            w_pat_next = w_pat_next ^ c_taps;
        end
    end
`else
    assign w_pat_next = r_pat + DATA_WIDTH'(1);
`endif

    always_ff @(posedge clk_i or negedge rst_bi) begin
        if (!rst_bi) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_pat       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state     <= S_WRITE;
                        r_addr      <= c_base;
                        r_pat       <= c_seed;
                        r_err_cnt   <= '0;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_wr        <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (done_i) begin
                        r_wr <= 1'b0;
                        if (w_last) begin
                            r_state <= S_RGAP;
                            r_addr  <= c_base;
                            r_pat   <= c_seed;
                        end else begin
                            r_state <= S_WGAP;
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                            r_pat   <= w_pat_next;
                        end
                    end
                end
                S_WGAP: begin
                    r_wr    <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_RGAP: begin
                    r_rd    <= 1'b1;
                    r_state <= S_READ;
                end
                S_READ: begin
                    if (rdDone_i) begin
                        r_rd  <= 1'b0;
                        r_pat <= w_pat_next;
                        if (data_i != r_pat) begin
                            if (r_err_cnt == '0) begin
                                r_fail_addr <= r_addr;
                                r_fail_data <= data_i;
                            end
                            if (r_err_cnt != c_err_max) begin
                                r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
                            end
                        end
                        if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_RGAP;
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_cnt == '0);
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign pass_o     = r_pass;
    assign errCnt_o   = r_err_cnt;
    assign failAddr_o = r_fail_addr;
    assign failData_o = r_fail_data;
    assign rd_o       = r_rd;
    assign wr_o       = r_wr;
    assign addr_o     = r_addr;
    assign data_o     = r_pat;

endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_pattern_tester
// Brief    : Randomized controller model and result scoreboard for
//            sdram_pattern_tester (either pattern build).
// Revision : 1.0
// ============================================================================
module tb_sdram_pattern_tester;

    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int BASE  = 'h10;
    localparam int NW    = 8;
    localparam int EW    = 2;
`ifdef PATTERN_LFSR_EN
    localparam logic [15:0] SEED_V = 16'hACE1;
`else
    localparam logic [15:0] SEED_V = 16'h0001;
`endif

    logic          clk = 1'b0;
    logic          rst_bi = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, pass_o, rd_o, wr_o;
    logic [EW-1:0] errCnt_o;
    logic [AW-1:0] failAddr_o, addr_o;
    logic [DW-1:0] failData_o, data_o;
    logic          opBegun_i = 1'b0;
    logic          done_i = 1'b0;
    logic          rdDone_i = 1'b0;
    logic [DW-1:0] data_i = '0;

    sdram_pattern_tester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .NUM_WORDS(NW), .SEED(SEED_V), .ERR_WIDTH(EW)
    ) dut (
        .clk_i(clk), .rst_bi(rst_bi), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .errCnt_o(errCnt_o), .failAddr_o(failAddr_o), .failData_o(failData_o),
        .rd_o(rd_o), .wr_o(wr_o), .addr_o(addr_o), .data_o(data_o),
        .opBegun_i(opBegun_i), .done_i(done_i), .rdDone_i(rdDone_i),
        .data_i(data_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected word k of a phase, straight from the pattern definition.
    function automatic logic [15:0] pat(input int k);
        logic [15:0] s;
        s = SEED_V;
`ifdef PATTERN_LFSR_EN
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
`else
        s = SEED_V + 16'(k);
`endif
        return s;
    endfunction

    // Scoreboard / controller-model state
    logic [DW-1:0] mem [NW];
    int  wr_idx, rd_idx, n_err, last_rd_cyc;
    logic [AW-1:0] first_addr;
    logic [DW-1:0] first_data;
    int  corrupt_mode;   // 0 none, 1 one word -> FFFF, 2 all words, 3 random words
    int  corrupt_idx;
    bit  spurious_en;

    initial begin : ctrl_model
        bit pend;
        int lat;
        logic [DW-1:0] v;
        pend = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            done_i = 1'b0;
            rdDone_i = 1'b0;
            if (!rst_bi) begin
                pend = 0;
            end else begin
                if (!pend && (wr_o || rd_o)) begin
                    pend = 1;
                    lat = $urandom_range(0, 3);
                    check("rd_wr_exclusive", {31'd0, rd_o & wr_o}, 32'd0);
                    if (wr_o) begin
                        check("wr_addr", addr_o, BASE + wr_idx);
                        check("wr_data", data_o, pat(wr_idx));
                    end else begin
                        check("rd_after_all_writes", wr_idx, NW);
                        check("rd_addr", addr_o, BASE + rd_idx);
                    end
                end
                if (pend) begin
                    if (lat == 0) begin
                        pend = 0;
                        if (wr_o) begin
                            done_i = 1'b1;
                            if (wr_idx < NW) mem[wr_idx] = data_o;
                            wr_idx++;
                        end else begin
                            v = (rd_idx < NW) ? mem[rd_idx] : '0;
                            if (corrupt_mode == 1 && rd_idx == corrupt_idx) v = 16'hFFFF;
                            else if (corrupt_mode == 2 || (corrupt_mode == 3 && $urandom_range(0, 2) == 0))
                                v = v ^ 16'($urandom_range(1, 16'hFFFF));
                            data_i = v;
                            rdDone_i = 1'b1;
                            if (v != pat(rd_idx)) begin
                                if (n_err == 0) begin
                                    first_addr = AW'(BASE + rd_idx);
                                    first_data = v;
                                end
                                n_err++;
                            end
                            rd_idx++;
                            last_rd_cyc = cyc;
                        end
                    end else begin
                        lat--;
                        if (spurious_en && $urandom_range(0, 3) == 0) begin
                            if (wr_o) begin
                                rdDone_i = 1'b1;
                                data_i = 16'($urandom);
                            end else begin
                                done_i = 1'b1;
                            end
                        end
                    end
                end else if (busy_o && spurious_en && $urandom_range(0, 2) == 0) begin
                    done_i = 1'b1;
                end
            end
        end
    end

    task automatic clear_model(input int mode);
        wr_idx = 0;
        rd_idx = 0;
        n_err = 0;
        first_addr = '0;
        first_data = '0;
        corrupt_mode = mode;
    endtask

    task automatic do_run(input int mode, input bit poke);
        int t;
        bit seen;
        clear_model(mode);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
        check("done_cleared", {31'd0, done_o}, 32'd0);
        seen = 0;
        for (t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1;
                break;
            end
            start_i = (poke && busy_o && $urandom_range(0, 5) == 0);
        end
        start_i = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("done_latency", cyc - last_rd_cyc, 2);
            check("words_written", wr_idx, NW);
            check("words_read", rd_idx, NW);
            check("status_flags", {27'd0, busy_o, done_o, pass_o, rd_o, wr_o},
                  {27'd0, 1'b0, 1'b1, (n_err == 0), 1'b0, 1'b0});
            check("err_cnt", errCnt_o, (n_err > 3) ? 3 : n_err);
            check("fail_addr", failAddr_o, first_addr);
            check("fail_data", failData_o, first_data);
            repeat (3) @(negedge clk);
            check("done_held", {30'd0, done_o, busy_o}, {30'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin : main
        int t;
        spurious_en = 0;
        clear_model(0);
        corrupt_idx = 2;
        #2;
        check("rst_flags", {27'd0, busy_o, done_o, pass_o, rd_o, wr_o}, 32'd0);
        check("rst_err", errCnt_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_data", data_o, 0);
        check("rst_fail", {failAddr_o, failData_o} != '0, 0);
        repeat (2) @(negedge clk);
        rst_bi = 1'b1;

        do_run(0, 0);                 // clean run
        do_run(1, 0);                 // word at BASE+2 reads back as FFFF
        do_run(2, 0);                 // every read corrupted, counter saturates
        spurious_en = 1;
        do_run(0, 1);                 // busy starts plus misdirected handshakes

        // reset during the second write
        clear_model(0);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (t = 0; t < 500; t++) begin
            if (wr_idx == 1 && wr_o) break;
            @(negedge clk);
        end
        check("reached_2nd_write", {31'd0, (wr_idx == 1 && wr_o)}, 32'd1);
        #2 rst_bi = 1'b0;
        #1;
        check("midrst_flags", {27'd0, busy_o, done_o, pass_o, rd_o, wr_o}, 32'd0);
        check("midrst_addr", addr_o, 0);
        check("midrst_data", data_o, 0);
        check("midrst_err", errCnt_o, 0);
        repeat (2) @(negedge clk);
        rst_bi = 1'b1;
        do_run(0, 0);

        for (int r = 0; r < 6; r++) begin
            corrupt_idx = $urandom_range(0, NW - 1);
            do_run($urandom_range(0, 3), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
